a2d_spi_resp: RTL and testbench

- Synthesizable SPI responder that emulates the 8-channel 12-bit A2D converter (ADC128S-style) at the far end of the eBike A2D SPI link.
- Captures the channel command sent on MOSI in one 16-bit frame and returns that channel's stored 12-bit value on MISO during the next frame.
- Used in the full-chip bench and on FPGA loopback builds, in place of the physical converter.
- Channel values are loaded through a simple parallel write port.

---
 rtl/a2d_pkg.sv | 19 +
 rtl/spi_in_synch.sv | 31 +++
 rtl/a2d_spi_resp.sv | 123 ++++++++++++
 tb/tb_a2d_spi_resp.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared constants and state type for the A2D SPI responder.
// Sized for an 8-channel, 12-bit converter behind a 16-bit frame.
package a2d_pkg;

  localparam int NUM_CH  = 8;
  localparam int DATA_W  = 12;
  localparam int FRAME_W = 16;
  localparam int CH_MSB  = 13;
  localparam int CH_LSB  = 11;
  localparam int CH_W    = CH_MSB - CH_LSB + 1;
  localparam int CNT_W   = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FINISH
  } resp_state_t;

endpackage

// File: rtl/spi_in_synch.sv
// Two-flop synchroniser plus an edge-detect flop.
// Produces single-clk rise and fall pulses.
module spi_in_synch (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;
  logic [2:0] prime;

  // Edges stay masked until the pin value has reached every flop,
  // so a line held low through reset never shows a phantom fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr    <= 3'b111;
      prime <= 3'b000;
    end else begin
      sr    <= {sr[1:0], din};
      prime <= {prime[1:0], 1'b1};
    end
  end

  assign dout = sr[1];
  assign rise = prime[2] & sr[1] & ~sr[2];
  assign fall = prime[2] & ~sr[1] & sr[2];

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder standing in for an 8-channel 12-bit A2D converter.
// Command captured in one frame selects the value returned in the next.
module a2d_spi_resp
  import a2d_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_chnl,
  input  logic [DATA_W-1:0] wr_data,
  output logic [CH_W-1:0]   cmd_chnl,
  output logic              xfer_done,
  output logic              frame_err
);

  logic ss_sync;
  logic ss_rise;
  logic ss_fall;
  logic sclk_sync;
  logic sclk_rise;
  logic sclk_fall;
  logic [1:0] mosi_ff;
  logic mosi_sync;

  resp_state_t state_q;
  resp_state_t state_d;

  logic [DATA_W-1:0]  tbl [NUM_CH];
  logic [FRAME_W-1:0] tx_shft;
  logic [CH_MSB:0]    rx_shft;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CH_W-1:0]    pend_ch;
  logic               frame_ok;

  spi_in_synch u_ss (
    .clk  (clk),
    .rst  (rst),
    .din  (SS_n),
    .dout (ss_sync),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  spi_in_synch u_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (SCLK),
    .dout (sclk_sync),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) mosi_ff <= 2'b00;
    else     mosi_ff <= {mosi_ff[0], MOSI};
  end

  assign mosi_sync = mosi_ff[1];
  assign frame_ok  = (bit_cnt == CNT_W'(FRAME_W));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ss_fall) state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) tbl[i] <= '0;
      tx_shft  <= '0;
      rx_shft  <= '0;
      bit_cnt  <= '0;
      pend_ch  <= '0;
      cmd_chnl <= '0;
    end else begin
      if (wr_en) tbl[wr_chnl] <= wr_data;
      unique case (state_q)
        IDLE: begin
          if (ss_fall) begin
            tx_shft <= {{(FRAME_W-DATA_W){1'b0}}, tbl[pend_ch]};
            bit_cnt <= '0;
          end
        end
        ACTIVE: begin
          // SS_n rise wins over any SCLK edge in the same clk
          if (!ss_rise) begin
            if (sclk_rise) begin
              rx_shft <= {rx_shft[CH_MSB-1:0], mosi_sync};
              if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
            end
            if (sclk_fall && bit_cnt != '0)
              tx_shft <= {tx_shft[FRAME_W-2:0], 1'b0};
          end
        end
        FINISH: begin
          if (frame_ok) begin
            pend_ch  <= rx_shft[CH_MSB:CH_LSB];
            cmd_chnl <= rx_shft[CH_MSB:CH_LSB];
          end
        end
        default: ;
      endcase
    end
  end

  assign MISO      = (state_q == ACTIVE) & tx_shft[FRAME_W-1];
  assign xfer_done = (state_q == FINISH) & frame_ok;
  assign frame_err = (state_q == FINISH) & ~frame_ok;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp with a channel-table reference model.
// Frames are driven at 16 clk per SCLK half-period.
module tb_a2d_spi_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_chnl = '0;
  logic [11:0] wr_data = '0;
  logic [2:0]  cmd_chnl;
  logic        xfer_done;
  logic        frame_err;

  a2d_spi_resp dut (
    .clk       (clk),
    .rst       (rst),
    .SS_n      (SS_n),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .wr_en     (wr_en),
    .wr_chnl   (wr_chnl),
    .wr_data   (wr_data),
    .cmd_chnl  (cmd_chnl),
    .xfer_done (xfer_done),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_xd   = 0;
  int n_fe   = 0;
  bit busy   = 1'b1;

  logic [11:0] mtbl [8];
  logic [2:0]  mpend;
  logic [2:0]  mcmd;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mtbl[i] = '0;
    mpend = '0;
    mcmd  = '0;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [11:0] v);
    wr_en   = 1'b1;
    wr_chnl = ch;
    wr_data = v;
    @(negedge clk);
    wr_en   = 1'b0;
    mtbl[ch] = v;
  endtask

  // Outside a frame the link must be quiet and cmd_chnl must hold.
  always @(negedge clk) begin
    if (!busy && !rst) begin
      n_chk++;
      if (MISO !== 1'b0 || cmd_chnl !== mcmd ||
          xfer_done !== 1'b0 || frame_err !== 1'b0) begin
        n_fail++;
        $display("FAIL idle: miso=%b cmd=%0d xd=%b fe=%b expected 0 %0d 0 0",
                 MISO, cmd_chnl, xfer_done, frame_err, mcmd);
      end
    end
  end

  always @(negedge clk) begin
    if (xfer_done === 1'b1) n_xd++;
    if (frame_err === 1'b1) n_fe++;
  end

  task automatic frame(input logic [15:0] cmd, input int nbits,
                       input int lit_rx, input int lit_cmd,
                       input int abort_at, input int wr_at,
                       input logic [2:0] wch, input logic [11:0] wval);
    logic [15:0] exp_word;
    logic [15:0] rxw;
    logic [15:0] exw;
    bit          aborted;
    int          w;
    exp_word = {4'b0000, mtbl[mpend]};
    rxw      = '0;
    exw      = '0;
    aborted  = 1'b0;
    busy     = 1'b1;
    n_xd     = 0;
    n_fe     = 0;
    SS_n     = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = cmd[15-i];
      w = 16;
      if (i == abort_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        aborted = 1'b1;
        w = 14;
      end
      if (i == wr_at) begin
        wr(wch, wval);
        w = w - 1;
      end
      repeat (w) @(negedge clk);
      rxw = {rxw[14:0], MISO};
      exw = {exw[14:0], aborted ? 1'b0 : exp_word[15-i]};
      SCLK = 1'b1;
      repeat (16) @(negedge clk);
    end
    SS_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("miso_word", int'(rxw), int'(exw));
    if (lit_rx >= 0) chk("miso_literal", int'(rxw), lit_rx);
    if (nbits == 16 && !aborted) begin
      mpend = cmd[13:11];
      mcmd  = cmd[13:11];
      chk("xfer_done_cnt", n_xd, 1);
      chk("frame_err_cnt", n_fe, 0);
    end else if (aborted) begin
      chk("xfer_done_cnt", n_xd, 0);
      chk("frame_err_cnt", n_fe, 0);
    end else begin
      chk("xfer_done_cnt", n_xd, 0);
      chk("frame_err_cnt", n_fe, 1);
    end
    chk("cmd_chnl", int'(cmd_chnl), int'(mcmd));
    if (lit_cmd >= 0) chk("cmd_literal", int'(cmd_chnl), lit_cmd);
    busy = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_miso", int'(MISO), 0);
    chk("rst_cmd", int'(cmd_chnl), 0);
    chk("rst_xd", int'(xfer_done), 0);
    chk("rst_fe", int'(frame_err), 0);
    busy = 1'b0;
    repeat (4) @(negedge clk);

    frame(16'h0800, 16, 16'h0000, 1, -1, -1, 3'd0, 12'h000);
    wr(3'd1, 12'hABC);
    frame(16'h2000, 16, 16'h0ABC, 4, -1, -1, 3'd0, 12'h000);
    wr(3'd4, 12'h123);
    wr(3'd7, 12'hFFF);
    frame(16'h3800, 16, 16'h0123, 7, -1, -1, 3'd0, 12'h000);
    frame(16'h1800, 16, 16'h0FFF, 3, -1, -1, 3'd0, 12'h000);
    wr(3'd3, 12'h321);
    frame(16'h1000, 10, 16'h000C, 3, -1, -1, 3'd0, 12'h000);
    frame(16'h1800, 16, 16'h0321, 3, -1, 6, 3'd3, 12'h5A5);
    frame(16'h0000, 16, 16'h05A5, 0, -1, -1, 3'd0, 12'h000);
    wr(3'd0, 12'h777);
    frame(16'h3800, 16, -1, 0, 7, -1, 3'd0, 12'h000);
    frame(16'hCFFF, 16, 16'h0000, 1, -1, -1, 3'd0, 12'h000);
    frame(16'h0000, 16, 16'h0000, 0, -1, -1, 3'd0, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
